// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//   Sequential unsigned multiplier using the classic shift-and-add algorithm.
//   A request is accepted only while idle. One LOAD cycle captures the
//   operands, then WIDTH CALC cycles each do a conditional add followed by a
//   right shift. The product register is updated on the final CALC edge and
//   holds its value at all other times.
//
// Ports
//   clk              : clock, all state updates on rising edge
//   rst              : asynchronous active-low reset
//   START            : start request, sampled only in IDLE
//   Multiplicand_bus : unsigned multiplicand (WIDTH bits), sampled in LOAD
//   Multiplier_bus   : unsigned multiplier (WIDTH bits), sampled in LOAD
//   product          : registered 2*WIDTH-bit result of last completed op
//   READY            : high while idle and able to accept START
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 START,
    input  logic [WIDTH-1:0]     Multiplicand_bus,
    input  logic [WIDTH-1:0]     Multiplier_bus,
    output logic [2*WIDTH-1:0]   product,
    output logic                 READY
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   sum;
    logic             last_iter;

    // The carry C only exists between the add and the shift of a single
    // CALC cycle: it is the MSB of sum and is shifted into A[WIDTH-1], so
    // after every edge the architectural C is zero and needs no flop.
    always_comb begin
        sum       = {1'b0, a_reg} + (q_reg[0] ? {1'b0, m_reg} : '0);
        last_iter = (count == CW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = START ? LOAD : IDLE;
            LOAD:    state_next = CALC;
            CALC:    state_next = last_iter ? IDLE : CALC;
            default: state_next = IDLE;
        endcase
    end

    // Moore output
    always_comb begin
        READY = (state == IDLE);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_reg   <= '0;
            a_reg   <= '0;
            q_reg   <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    m_reg <= Multiplicand_bus;
                    q_reg <= Multiplier_bus;
                    a_reg <= '0;
                    count <= '0;
                end
                CALC: begin
                    // {C,A,Q} <= {sum, Q} >> 1
                    a_reg <= sum[WIDTH:1];
                    q_reg <= {sum[0], q_reg[WIDTH-1:1]};
                    count <= count + CW'(1);
                    if (last_iter) begin
                        product <= {sum[WIDTH:1], sum[0], q_reg[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
REQ-003 SHALL have port: START  input  1  request a multiplication; sampled on rising clk only while idle.
REQ-004 SHALL have port: Multiplicand_bus  input  8  unsigned multiplicand; sampled in LOAD cycle.
REQ-005 SHALL have port: Multiplier_bus  input  8  unsigned multiplier; sampled in LOAD cycle.
REQ-006 SHALL have port: product  output  16  registered unsigned result of last completed operation.
REQ-007 SHALL have port: READY  output  1  high when idle and able to accept START.
REQ-008 SHALL define parameter: WIDTH, default 8, operand width; product is 2*WIDTH; counter is clog2(WIDTH)+1 bits.

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, CALC; READY=1 only in IDLE (Moore output).
REQ-010 SHALL go IDLE->LOAD on rising edge with START=1; stay in IDLE while START=0.
REQ-011 SHALL, in LOAD (one cycle), load M<=Multiplicand_bus, Q<=Multiplier_bus, clear A (WIDTH bits) and carry C, clear iteration counter; then go to CALC.
REQ-012 SHALL, each CALC cycle: if Q[0]=1, {C,A}<=A+M (WIDTH+1-bit sum) combined with right shift, i.e. {C,A,Q}<=({C,A+M*Q[0]},Q)>>1 in one edge; increment counter.
REQ-013 SHALL run exactly WIDTH CALC cycles, then return to IDLE.
REQ-014 SHALL load product<={A,Q} (post-final-shift value) on the CALC->IDLE edge; product SHALL hold unchanged at all other times, including through LOAD/CALC of a subsequent operation.
REQ-015 SHALL give latency: START sampled at edge N -> READY low after edge N, product valid and READY high after edge N+1+WIDTH (N+9 at WIDTH=8).
REQ-016 SHALL ignore START while in LOAD or CALC; operands SHALL NOT be resampled mid-operation.
REQ-017 SHALL, if START=1 on the edge that returns to IDLE, not start (START is sampled only in IDLE); START held high in IDLE gives back-to-back operations with one IDLE cycle between them.
REQ-018 SHALL produce exact unsigned result, no overflow possible: max 255*255=65025 (0xFE01).
REQ-019 SHALL make operand changes after LOAD have no effect on the result.
REQ-020 SHALL have no combinational path from any input to any output.

Reset
REQ-021 SHALL, on rst=0, asynchronously force state=IDLE, product=0x0000, READY=1, A=Q=M=0, C=0, counter=0.
REQ-022 SHALL abort any in-progress operation on reset with no product update; first START after rst rises starts a clean operation.
REQ-023 SHALL hold all outputs at reset values while rst=0 regardless of clk/START.

Verification
REQ-024 SHALL verify: reset, START pulse with 13 x 11 -> READY low next cycle, READY high 9 edges later, product=0x008F (143).
REQ-025 SHALL verify: 255 x 255 -> product=0xFE01; 0 x 200 and 200 x 0 -> product=0x0000; 1 x 173 -> 0x00AD.
REQ-026 SHALL verify: 6 x 7 started, START pulsed and operands changed to 9 x 9 during CALC -> product=0x002A, no second operation begins.
REQ-027 SHALL verify: 100 x 3 completed (0x012C), then rst=0 at 4th CALC cycle of 50 x 50 -> product=0x0000 and READY=1 immediately, before next clk edge.
REQ-028 SHALL verify: START held high, operands 2 x 3 then 4 x 5 -> product 0x0006 then 0x0014, each READY high exactly one cycle between operations.
REQ-029 SHALL verify via scoreboard: 1000 random operand pairs -> product equals a*b for every completion.
